// File: rtl/sda_gmem_read_arbiter.sv
// ============================================================================
// Module  : sda_gmem_read_arbiter
// Brief   : Two-requester gmem AXI read arbiter with in-order R steering.
//           Build option GMEM_READ_ARB_ROUND_ROBIN_EN selects round-robin
//           arbitration; otherwise port 0 has fixed priority.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sda_gmem_read_arbiter #(
  parameter int ADDR_WIDTH  = 64,
  parameter int DATA_WIDTH  = 32,
  parameter int OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  // requester 0
  input  logic [ADDR_WIDTH-1:0] s0_araddr,
  input  logic [7:0]            s0_arlen,
  input  logic [2:0]            s0_arsize,
  input  logic [1:0]            s0_arburst,
  input  logic [1:0]            s0_armtype,
  input  logic                  s0_arvalid,
  output logic                  s0_arready,
  output logic [DATA_WIDTH-1:0] s0_rdata,
  output logic [1:0]            s0_rresp,
  output logic                  s0_rlast,
  output logic                  s0_rvalid,
  input  logic                  s0_rready,
  // requester 1
  input  logic [ADDR_WIDTH-1:0] s1_araddr,
  input  logic [7:0]            s1_arlen,
  input  logic [2:0]            s1_arsize,
  input  logic [1:0]            s1_arburst,
  input  logic [1:0]            s1_armtype,
  input  logic                  s1_arvalid,
  output logic                  s1_arready,
  output logic [DATA_WIDTH-1:0] s1_rdata,
  output logic [1:0]            s1_rresp,
  output logic                  s1_rlast,
  output logic                  s1_rvalid,
  input  logic                  s1_rready,
  // gmem master
  output logic [ADDR_WIDTH-1:0] m_axi_gmem_araddr,
  output logic [7:0]            m_axi_gmem_arlen,
  output logic [2:0]            m_axi_gmem_arsize,
  output logic [1:0]            m_axi_gmem_arburst,
  output logic [1:0]            m_axi_gmem_armtype,
  output logic                  m_axi_gmem_arvalid,
  input  logic                  m_axi_gmem_arready,
  input  logic [DATA_WIDTH-1:0] m_axi_gmem_rdata,
  input  logic [1:0]            m_axi_gmem_rresp,
  input  logic                  m_axi_gmem_rlast,
  input  logic                  m_axi_gmem_rvalid,
  output logic                  m_axi_gmem_rready,
  output logic                  busy
);

  localparam int PW = $clog2(OUTSTANDING);
  localparam int CW = PW + 1;

  typedef enum logic [0:0] {IDLE = 1'b0, ISSUE = 1'b1} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           count_q;
  logic [PW-1:0]           wr_ptr_q, rd_ptr_q;
  logic [OUTSTANDING-1:0]  own_q;
  logic [ADDR_WIDTH-1:0]   araddr_q;
  logic [7:0]              arlen_q;
  logic [2:0]              arsize_q;
  logic [1:0]              arburst_q, armtype_q;

  logic w_full, w_empty, w_any, w_grant, w_grant_id, w_owner, w_pop;

  assign w_full  = (count_q == CW'(OUTSTANDING));
  assign w_empty = (count_q == '0);
  assign w_any   = s0_arvalid | s1_arvalid;

`ifdef GMEM_READ_ARB_ROUND_ROBIN_EN
  logic last_grant_q;
  // On contention the port that did not win last time goes first.
  assign w_grant_id = (s0_arvalid & s1_arvalid) ? ~last_grant_q : s1_arvalid;
`else
  assign w_grant_id = ~s0_arvalid & s1_arvalid;
`endif

  // Reset gating keeps the combinational handshake quiet while reset is held.
  assign w_grant    = ~reset & (state_q == IDLE) & ~w_full & w_any;
  assign s0_arready = w_grant & ~w_grant_id;
  assign s1_arready = w_grant &  w_grant_id;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (w_grant) state_d = ISSUE;
      ISSUE:   if (m_axi_gmem_arready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign w_owner           = own_q[rd_ptr_q];
  assign s0_rvalid         = m_axi_gmem_rvalid & ~w_empty & ~w_owner;
  assign s1_rvalid         = m_axi_gmem_rvalid & ~w_empty &  w_owner;
  assign m_axi_gmem_rready = ~w_empty & (w_owner ? s1_rready : s0_rready);
  assign w_pop             = m_axi_gmem_rvalid & m_axi_gmem_rready & m_axi_gmem_rlast;

  assign s0_rdata = m_axi_gmem_rdata;
  assign s0_rresp = m_axi_gmem_rresp;
  assign s0_rlast = m_axi_gmem_rlast;
  assign s1_rdata = m_axi_gmem_rdata;
  assign s1_rresp = m_axi_gmem_rresp;
  assign s1_rlast = m_axi_gmem_rlast;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      own_q     <= '0;
      araddr_q  <= '0;
      arlen_q   <= '0;
      arsize_q  <= '0;
      arburst_q <= '0;
      armtype_q <= '0;
    end else begin
      state_q <= state_d;
      if (w_grant) begin
        own_q[wr_ptr_q] <= w_grant_id;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
        araddr_q        <= w_grant_id ? s1_araddr  : s0_araddr;
        arlen_q         <= w_grant_id ? s1_arlen   : s0_arlen;
        arsize_q        <= w_grant_id ? s1_arsize  : s0_arsize;
        arburst_q       <= w_grant_id ? s1_arburst : s0_arburst;
        armtype_q       <= w_grant_id ? s1_armtype : s0_armtype;
      end
      if (w_pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      // Push and pop together leave the count untouched.
      if (w_grant && !w_pop)      count_q <= count_q + CW'(1);
      else if (!w_grant && w_pop) count_q <= count_q - CW'(1);
    end
  end

`ifdef GMEM_READ_ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        last_grant_q <= 1'b1;
    else if (w_grant) last_grant_q <= w_grant_id;
  end
`endif

  assign m_axi_gmem_araddr  = araddr_q;
  assign m_axi_gmem_arlen   = arlen_q;
  assign m_axi_gmem_arsize  = arsize_q;
  assign m_axi_gmem_arburst = arburst_q;
  assign m_axi_gmem_armtype = armtype_q;
  assign m_axi_gmem_arvalid = (state_q == ISSUE);
  assign busy               = (state_q == ISSUE) | ~w_empty;

endmodule

`default_nettype wire

// File: tb/tb_sda_gmem_read_arbiter.sv
// ============================================================================
// Module  : tb_sda_gmem_read_arbiter
// Brief   : Directed self-checking bench for sda_gmem_read_arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sda_gmem_read_arbiter;

  logic        clk, reset;
  logic [63:0] s0_araddr, s1_araddr, m_araddr;
  logic [7:0]  s0_arlen, s1_arlen, m_arlen;
  logic [2:0]  s0_arsize, s1_arsize, m_arsize;
  logic [1:0]  s0_arburst, s1_arburst, m_arburst, s0_armtype, s1_armtype, m_armtype;
  logic        s0_arvalid, s1_arvalid, s0_arready, s1_arready;
  logic [31:0] s0_rdata, s1_rdata, m_rdata;
  logic [1:0]  s0_rresp, s1_rresp, m_rresp;
  logic        s0_rlast, s1_rlast, m_rlast;
  logic        s0_rvalid, s1_rvalid, s0_rready, s1_rready;
  logic        m_arvalid, m_arready, m_rvalid, m_rready, busy;

  int pass_cnt = 0;
  int total_cnt = 0;

  sda_gmem_read_arbiter #(.ADDR_WIDTH(64), .DATA_WIDTH(32), .OUTSTANDING(4)) dut (
    .clk(clk), .reset(reset),
    .s0_araddr(s0_araddr), .s0_arlen(s0_arlen), .s0_arsize(s0_arsize),
    .s0_arburst(s0_arburst), .s0_armtype(s0_armtype), .s0_arvalid(s0_arvalid),
    .s0_arready(s0_arready), .s0_rdata(s0_rdata), .s0_rresp(s0_rresp),
    .s0_rlast(s0_rlast), .s0_rvalid(s0_rvalid), .s0_rready(s0_rready),
    .s1_araddr(s1_araddr), .s1_arlen(s1_arlen), .s1_arsize(s1_arsize),
    .s1_arburst(s1_arburst), .s1_armtype(s1_armtype), .s1_arvalid(s1_arvalid),
    .s1_arready(s1_arready), .s1_rdata(s1_rdata), .s1_rresp(s1_rresp),
    .s1_rlast(s1_rlast), .s1_rvalid(s1_rvalid), .s1_rready(s1_rready),
    .m_axi_gmem_araddr(m_araddr), .m_axi_gmem_arlen(m_arlen),
    .m_axi_gmem_arsize(m_arsize), .m_axi_gmem_arburst(m_arburst),
    .m_axi_gmem_armtype(m_armtype), .m_axi_gmem_arvalid(m_arvalid),
    .m_axi_gmem_arready(m_arready), .m_axi_gmem_rdata(m_rdata),
    .m_axi_gmem_rresp(m_rresp), .m_axi_gmem_rlast(m_rlast),
    .m_axi_gmem_rvalid(m_rvalid), .m_axi_gmem_rready(m_rready),
    .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    s0_arvalid = 1'b0; s1_arvalid = 1'b0;
    s0_rready = 1'b0;  s1_rready = 1'b0;
    m_rvalid = 1'b0;   m_rlast = 1'b0;
    m_arready = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    s0_arvalid = 1'b1;
    #2;
    total_cnt++; if (s0_arready !== 1'b0) $display("FAIL reset_s0_arready got=%b want=0", s0_arready); else pass_cnt++;
    total_cnt++; if (s1_arready !== 1'b0) $display("FAIL reset_s1_arready got=%b want=0", s1_arready); else pass_cnt++;
    total_cnt++; if (m_arvalid !== 1'b0) $display("FAIL reset_arvalid got=%b want=0", m_arvalid); else pass_cnt++;
    total_cnt++; if (m_araddr !== 64'h0 || m_arlen !== 8'h0) $display("FAIL reset_ar_fields got=%h/%h want=0/0", m_araddr, m_arlen); else pass_cnt++;
    total_cnt++; if (m_rready !== 1'b0) $display("FAIL reset_rready got=%b want=0", m_rready); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0 || s0_rvalid !== 1'b0 || s1_rvalid !== 1'b0) $display("FAIL reset_busy_rvalid got=%b%b%b want=000", busy, s0_rvalid, s1_rvalid); else pass_cnt++;
    s0_arvalid = 1'b0;
  endtask

  task automatic test_single_burst();
    do_reset();
    s0_araddr = 64'h1000; s0_arlen = 8'd3; s0_arsize = 3'd2; s0_arburst = 2'd1; s0_armtype = 2'd2;
    s0_arvalid = 1'b1;
    #1;
    total_cnt++; if (s0_arready !== 1'b1 || s1_arready !== 1'b0) $display("FAIL single_grant got=%b%b want=10", s0_arready, s1_arready); else pass_cnt++;
    total_cnt++; if (m_arvalid !== 1'b0) $display("FAIL single_arvalid_T got=%b want=0", m_arvalid); else pass_cnt++;
    tick();
    s0_arvalid = 1'b0;
    #1;
    total_cnt++; if (m_arvalid !== 1'b1 || s0_arready !== 1'b0) $display("FAIL single_arvalid_T1 got=%b/%b want=1/0", m_arvalid, s0_arready); else pass_cnt++;
    total_cnt++; if (m_araddr !== 64'h1000 || m_arlen !== 8'd3 || m_arsize !== 3'd2 || m_arburst !== 2'd1 || m_armtype !== 2'd2)
      $display("FAIL single_ar_fields got=%h/%h/%h/%h/%h want=1000/03/2/1/2", m_araddr, m_arlen, m_arsize, m_arburst, m_armtype); else pass_cnt++;
    tick();
    total_cnt++; if (m_arvalid !== 1'b0 || busy !== 1'b1) $display("FAIL single_after_issue got=%b/%b want=0/1", m_arvalid, busy); else pass_cnt++;
    s0_rready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      m_rvalid = 1'b1; m_rdata = 32'hA0 + 32'(i); m_rresp = 2'd0; m_rlast = (i == 3);
      #1;
      total_cnt++; if (s0_rvalid !== 1'b1 || s1_rvalid !== 1'b0 || m_rready !== 1'b1)
        $display("FAIL single_beat%0d got=%b%b%b want=101", i, s0_rvalid, s1_rvalid, m_rready); else pass_cnt++;
      total_cnt++; if (s0_rdata !== 32'hA0 + 32'(i) || s1_rdata !== 32'hA0 + 32'(i) || s0_rlast !== (i == 3))
        $display("FAIL single_data%0d got=%h/%h/%b want=%h", i, s0_rdata, s1_rdata, s0_rlast, 32'hA0 + 32'(i)); else pass_cnt++;
      tick();
    end
    m_rvalid = 1'b0; m_rlast = 1'b0;
    #1;
    total_cnt++; if (busy !== 1'b0) $display("FAIL single_busy_end got=%b want=0", busy); else pass_cnt++;
  endtask

  task automatic test_contention();
    int got[4];
    int exp_g[4];
    int n = 0;
`ifdef GMEM_READ_ARB_ROUND_ROBIN_EN
    exp_g = '{0, 1, 0, 1};
`else
    exp_g = '{0, 0, 0, 0};
`endif
    do_reset();
    s0_araddr = 64'h100; s1_araddr = 64'h200;
    s0_arvalid = 1'b1; s1_arvalid = 1'b1;
    #1;
    for (int c = 0; c < 20 && n < 4; c++) begin
      if (s0_arready) begin got[n] = 0; n++; end
      else if (s1_arready) begin got[n] = 1; n++; end
      @(posedge clk); #2;
    end
    s0_arvalid = 1'b0; s1_arvalid = 1'b0;
    total_cnt++; if (n !== 4) $display("FAIL contention_count got=%0d want=4", n); else pass_cnt++;
    for (int k = 0; k < 4; k++) begin
      total_cnt++; if (k >= n || got[k] !== exp_g[k]) $display("FAIL contention_order%0d got=%0d want=%0d", k, (k < n) ? got[k] : -1, exp_g[k]); else pass_cnt++;
    end
  endtask

  task automatic test_ordering();
    do_reset();
    s1_araddr = 64'h3000; s1_arlen = 8'd1; s1_arvalid = 1'b1;
    #1;
    total_cnt++; if (s1_arready !== 1'b1) $display("FAIL order_grant_s1 got=%b want=1", s1_arready); else pass_cnt++;
    tick(); s1_arvalid = 1'b0;
    tick();
    s0_araddr = 64'h4000; s0_arlen = 8'd0; s0_arvalid = 1'b1;
    #1;
    total_cnt++; if (s0_arready !== 1'b1) $display("FAIL order_grant_s0 got=%b want=1", s0_arready); else pass_cnt++;
    tick(); s0_arvalid = 1'b0;
    tick();
    s0_rready = 1'b1; s1_rready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      m_rvalid = 1'b1; m_rdata = 32'h55 + 32'(i); m_rlast = (i != 0);
      #1;
      total_cnt++; if (s0_rvalid !== (i == 2) || s1_rvalid !== (i != 2))
        $display("FAIL order_beat%0d got=s0:%b s1:%b want=s0:%b s1:%b", i, s0_rvalid, s1_rvalid, (i == 2), (i != 2)); else pass_cnt++;
      tick();
    end
    m_rvalid = 1'b0; m_rlast = 1'b0;
    #1;
    total_cnt++; if (busy !== 1'b0) $display("FAIL order_busy_end got=%b want=0", busy); else pass_cnt++;
  endtask

  task automatic test_full();
    int g = 0;
    do_reset();
    s0_araddr = 64'h5000; s0_arlen = 8'd0; s0_arvalid = 1'b1;
    #1;
    for (int c = 0; c < 14; c++) begin
      if (s0_arready) g++;
      @(posedge clk); #2;
    end
    total_cnt++; if (g !== 4) $display("FAIL full_grants got=%0d want=4", g); else pass_cnt++;
    total_cnt++; if (s0_arready !== 1'b0) $display("FAIL full_fifth_held got=%b want=0", s0_arready); else pass_cnt++;
    s0_rready = 1'b1; m_rvalid = 1'b1; m_rlast = 1'b1;
    #1;
    total_cnt++; if (m_rready !== 1'b1 || s0_arready !== 1'b0)
      $display("FAIL full_pop_cycle got=rready:%b arready:%b want=1/0", m_rready, s0_arready); else pass_cnt++;
    tick();
    m_rvalid = 1'b0; m_rlast = 1'b0;
    #1;
    total_cnt++; if (s0_arready !== 1'b1) $display("FAIL full_fifth_grant got=%b want=1", s0_arready); else pass_cnt++;
    tick();
    s0_arvalid = 1'b0;
  endtask

  task automatic test_backpressure();
    int bad = 0;
    do_reset();
    m_arready = 1'b0;
    s0_araddr = 64'h2000; s0_arlen = 8'd7; s0_arvalid = 1'b1;
    #1;
    total_cnt++; if (s0_arready !== 1'b1) $display("FAIL bp_grant got=%b want=1", s0_arready); else pass_cnt++;
    tick();
    s0_arvalid = 1'b0; s0_araddr = 64'hDEAD; s1_araddr = 64'h7000; s1_arvalid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (m_arvalid !== 1'b1 || m_araddr !== 64'h2000 || m_arlen !== 8'd7 || s1_arready !== 1'b0) bad++;
      tick();
    end
    total_cnt++; if (bad !== 0) $display("FAIL bp_stable got=%0d bad cycles want=0", bad); else pass_cnt++;
    s0_rready = 1'b0; m_rvalid = 1'b1;
    #1;
    total_cnt++; if (m_rready !== 1'b0 || s0_rvalid !== 1'b1) $display("FAIL bp_rready got=rready:%b s0_rvalid:%b want=0/1", m_rready, s0_rvalid); else pass_cnt++;
    m_rvalid = 1'b0;
    m_arready = 1'b1;
    tick();
    #1;
    total_cnt++; if (m_arvalid !== 1'b0 || s1_arready !== 1'b1) $display("FAIL bp_release got=arvalid:%b s1_arready:%b want=0/1", m_arvalid, s1_arready); else pass_cnt++;
    s1_arvalid = 1'b0;
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    s0_araddr = 64'h9000; s0_arlen = 8'd3; s0_arvalid = 1'b1;
    tick(); s0_arvalid = 1'b0;
    tick();
    s0_rready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      m_rvalid = 1'b1; m_rlast = 1'b0;
      tick();
    end
    #2;
    reset = 1'b1;
    #1;
    total_cnt++; if (busy !== 1'b0 || m_rready !== 1'b0 || s0_rvalid !== 1'b0)
      $display("FAIL midreset_r got=busy:%b rready:%b s0_rvalid:%b want=0/0/0", busy, m_rready, s0_rvalid); else pass_cnt++;
    total_cnt++; if (m_arvalid !== 1'b0 || m_araddr !== 64'h0 || m_arlen !== 8'h0)
      $display("FAIL midreset_ar got=%b/%h/%h want=0/0/0", m_arvalid, m_araddr, m_arlen); else pass_cnt++;
    m_rvalid = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    total_cnt++; if (busy !== 1'b0 || m_rready !== 1'b0) $display("FAIL midreset_after got=busy:%b rready:%b want=0/0", busy, m_rready); else pass_cnt++;
  endtask

  initial begin
    reset = 1'b1;
    s0_araddr = '0; s0_arlen = '0; s0_arsize = '0; s0_arburst = '0; s0_armtype = '0;
    s1_araddr = '0; s1_arlen = '0; s1_arsize = '0; s1_arburst = '0; s1_armtype = '0;
    s0_arvalid = 1'b0; s1_arvalid = 1'b0; s0_rready = 1'b0; s1_rready = 1'b0;
    m_arready = 1'b0; m_rdata = '0; m_rresp = '0; m_rlast = 1'b0; m_rvalid = 1'b0;
    test_reset();
    test_single_burst();
    test_contention();
    test_ordering();
    test_full();
    test_backpressure();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=no finish want=finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/sda_gmem_read_arbiter.md
# sda_gmem_read_arbiter

Shares the single gmem AXI read master between two independent read requesters inside the generated action logic. Requester bursts are accepted through a registered read-address stage using round-robin arbitration. Burst ownership is recorded in an in-order FIFO, and read-data beats are steered back to the owning requester until RLAST. Sits between the action datapath read ports and the gmem AR/R channels of the kernel wrapper.

## Interface
- ADDR_WIDTH, 64, gmem byte address width
- DATA_WIDTH, 32, gmem data width
- OUTSTANDING, 4, maximum accepted-but-incomplete bursts; power of two, at least 2

Ports (N = 0, 1; one port per requester):
- clk  input  1  clock
- reset  input  1  reset, asynchronous and active-high
- sN_araddr  input  ADDR_WIDTH  requester N burst address
- sN_arlen / sN_arsize / sN_arburst / sN_armtype  input  8 / 3 / 2 / 2  requester N burst attributes
- sN_arvalid  input  1  requester N address valid
- sN_arready  output  1  requester N address accepted
- sN_rdata / sN_rresp / sN_rlast  output  DATA_WIDTH / 2 / 1  broadcast copies of m_axi_gmem_rdata / rresp / rlast
- sN_rvalid  output  1  data beat valid for requester N
- sN_rready  input  1  requester N data ready
- m_axi_gmem_araddr / arlen / arsize / arburst / armtype  output  ADDR_WIDTH / 8 / 3 / 2 / 2  registered address fields
- m_axi_gmem_arvalid  output  1  address valid
- m_axi_gmem_arready  input  1  address ready
- m_axi_gmem_rdata / rresp / rlast / rvalid  input  DATA_WIDTH / 2 / 1 / 1  read data channel
- m_axi_gmem_rready  output  1  read data ready
- busy  output  1  high while state is ISSUE or any burst is outstanding

## Operation
- Address FSM has two states, IDLE and ISSUE. Reset state is IDLE.
- IDLE: the FSM grants when count < OUTSTANDING and at least one sN_arvalid is high.
  - Pulse the winner's sN_arready for one cycle.
  - Register the winner's AR fields into the m_axi_gmem_ar* registers.
  - Push the winner's ID into the ownership FIFO and increment count.
  - Go to ISSUE.
- ISSUE: hold m_axi_gmem_arvalid high with stable fields until m_axi_gmem_arready is high, then return to IDLE.
- Arbitration: last_grant register, reset value 1.
  - If only one port is valid, that port wins.
  - If both are valid, the port not equal to last_grant wins.
  - last_grant updates on every grant.
- Full check uses the registered count only. A pop in the same cycle does not allow a grant while full.
- R steering: owner is the head of the ownership FIFO.
  - sN_rvalid = m_axi_gmem_rvalid & ~empty & (owner == N).
  - m_axi_gmem_rready = ~empty & owner's sN_rready.
  - When empty, m_axi_gmem_rready is 0 and stray beats are stalled.
- Pop: on an accepted beat (rvalid & rready) with rlast=1, pop the FIFO and decrement count.
- Simultaneous grant push and rlast pop: count is unchanged and FIFO pointers both advance.
- FIFO pointer width is log2(OUTSTANDING), wrapping naturally. Count width is log2(OUTSTANDING)+1.
- Reset at any time clears the FIFO, count, FSM and address registers. Outstanding bursts are discarded. gmem must be reset in the same domain.

## Timing
- Reset values:
  - sN_arready = 0, sN_rvalid = 0.
  - m_axi_gmem_arvalid = 0, all m_axi_gmem_ar* fields = 0.
  - m_axi_gmem_rready = 0, busy = 0.
- sN_arready is combinational: state == IDLE & ~full & grant == N.
- Address latency: a grant in cycle T gives m_axi_gmem_arvalid = 1 from T+1.
- Address throughput: at most one burst per 2 cycles (grant cycle plus at least one ISSUE cycle).
- R path is fully combinational with zero added latency. rdata, rresp and rlast pass straight through to both ports.
- m_axi_gmem_ar* fields never change while m_axi_gmem_arvalid=1 and m_axi_gmem_arready=0.

## Configuration
- GMEM_READ_ARB_ROUND_ROBIN_EN
  - Defined: round-robin arbitration as described above.
  - Undefined: fixed priority, port 0 always wins when both are valid. The last_grant register is not implemented.
  - All other behaviour is identical in both builds.

## Test plan
- **Single burst.** Reset, then s0 requests araddr=0x1000, arlen=3; m_axi_gmem_arready=1; return 4 beats with rlast on beat 4.
  - s0_arready pulses at T; m_axi_gmem_arvalid rises at T+1.
  - s0_rvalid sees 4 beats; s1_rvalid stays 0; busy falls after the last beat.
- **Contention.** s0 and s1 are both valid continuously for 4 grants.
  - Round robin: grant order 0,1,0,1.
  - Fixed priority (macro undefined): 0,0,0,0.
- **Ordering.** Issue s1 (arlen=1), then s0 (arlen=0); return 3 beats.
  - Beats 1-2 go to s1 only; beat 3 goes to s0 only.
- **Full.** OUTSTANDING=4, hold m_axi_gmem_rvalid=0, issue 5 requests.
  - Exactly 4 grants occur; the 5th arready is held low.
  - Completing one burst (rlast) lets the 5th grant follow on a later cycle.
- **Backpressure.** m_axi_gmem_arready=0 for 10 cycles, then 1.
  - arvalid and address stay stable for all 10 cycles; no new grant during ISSUE.
  - With s0_rready=0, m_axi_gmem_rready is 0.
- **Reset mid-burst.** Assert reset between beat 2 and beat 3 of a 4-beat burst.
  - All outputs return to reset values asynchronously; busy=0; count=0.
